// File: rtl/bht_sweep_ctrl_pkg.sv
// Purpose: shared types and constants for the BRAM-based BHT write-port controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bht_sweep_ctrl_pkg;

    // Instruction slots per fetch block; one BHT bank per slot.
    localparam int unsigned INSTR_PER_FETCH = 2;

    // One BHT RAM entry as stored in BRAM.
    typedef struct packed {
        logic       valid;
        logic [1:0] saturation_counter;
    } bht_ram_entry_t;

    localparam int unsigned BHT_ENTRY_W = $bits(bht_ram_entry_t);

    // Pattern written after reset.
    localparam bht_ram_entry_t BHT_INIT_ENTRY  = '0;
    // Pattern written after a flush: invalid, weakly taken.
    localparam bht_ram_entry_t BHT_FLUSH_ENTRY = 3'b010;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/bht_sweep_ctrl.sv
// Purpose: sweeps every BHT row after reset/flush and otherwise forwards commit-time
//          BHT updates to the single shared write port of the banked BHT RAMs.
// Latency: updates reach the RAM write port combinationally (zero cycles).
// Backpressure: none; updates arriving during a sweep or with a flush are dropped and counted.
// Ports: clk_i/rst_i clock and async active-high reset; flush_i, debug_mode_i control;
//        upd_* update request; ram_* banked write port; busy_o, sweep_done_o, drop_cnt_o status.
module bht_sweep_ctrl
    import bht_sweep_ctrl_pkg::*;
#(
    parameter int unsigned NR_ROWS    = 256,
    parameter int unsigned NR_BANKS   = INSTR_PER_FETCH,
    parameter int unsigned DROP_CNT_W = 16,
    localparam int unsigned ROW_W     = $clog2(NR_ROWS),
    localparam int unsigned BANK_W    = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            debug_mode_i,
    input  logic                            upd_valid_i,
    input  logic [ROW_W-1:0]                upd_row_i,
    input  logic [BANK_W-1:0]               upd_bank_i,
    input  logic [BHT_ENTRY_W-1:0]          upd_wdata_i,
    output logic [NR_BANKS-1:0]             ram_we_o,
    output logic [ROW_W-1:0]                ram_waddr_o,
    output logic [NR_BANKS*BHT_ENTRY_W-1:0] ram_wdata_o,
    output logic                            busy_o,
    output logic                            sweep_done_o,
    output logic [DROP_CNT_W-1:0]           drop_cnt_o
);

    sweep_state_e          state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  sweep_done_q, sweep_done_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic upd_req;
    assign upd_req = upd_valid_i && !debug_mode_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= INIT;
            row_q        <= '0;
            sweep_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            sweep_done_q <= sweep_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        sweep_done_d = 1'b0;
        case (state_q)
            INIT, FLUSH: begin
                // A flush mid-sweep restarts from row 0 with the flush pattern and
                // suppresses the completion pulse, even on the last row.
                if (flush_i) begin
                    state_d = FLUSH;
                    row_d   = '0;
                end else if (row_q == ROW_W'(NR_ROWS - 1)) begin
                    state_d      = IDLE;
                    row_d        = '0;
                    sweep_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            default: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    row_d   = '0;
                end
            end
        endcase

        drop_cnt_d = drop_cnt_q;
        if (upd_req && (state_q != IDLE || flush_i) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    // Output logic
    always_comb begin
        bht_ram_entry_t sweep_pat;
        sweep_pat   = (state_q == FLUSH) ? BHT_FLUSH_ENTRY : BHT_INIT_ENTRY;
        ram_we_o    = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        if (rst_i) begin
            // Write port stays quiet while reset is held.
            ram_we_o = '0;
        end else if (state_q != IDLE) begin
            ram_we_o    = '1;
            ram_waddr_o = row_q;
            for (int unsigned b = 0; b < NR_BANKS; b++) begin
                ram_wdata_o[b*BHT_ENTRY_W +: BHT_ENTRY_W] = sweep_pat;
            end
        end else if (upd_req && !flush_i) begin
            ram_waddr_o = upd_row_i;
            for (int unsigned b = 0; b < NR_BANKS; b++) begin
                if (upd_bank_i == BANK_W'(b)) begin
                    ram_we_o[b]                                = 1'b1;
                    ram_wdata_o[b*BHT_ENTRY_W +: BHT_ENTRY_W] = upd_wdata_i;
                end
            end
        end
    end

    assign busy_o       = (state_q != IDLE) || rst_i;
    assign sweep_done_o = sweep_done_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_bht_sweep_ctrl.sv
module tb_bht_sweep_ctrl;

    localparam int NR_ROWS = 8;
    localparam int NR_BANKS = 2;
    localparam int DROP_W = 2;
    localparam int DROP_MAX = 3;

    logic       clk_i = 1'b0;
    logic       rst_i, flush_i, debug_mode_i, upd_valid_i;
    logic [2:0] upd_row_i;
    logic [0:0] upd_bank_i;
    logic [2:0] upd_wdata_i;
    logic [1:0] ram_we_o;
    logic [2:0] ram_waddr_o;
    logic [5:0] ram_wdata_o;
    logic       busy_o, sweep_done_o;
    logic [1:0] drop_cnt_o;

    bht_sweep_ctrl #(.NR_ROWS(NR_ROWS), .NR_BANKS(NR_BANKS), .DROP_CNT_W(DROP_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .upd_valid_i(upd_valid_i), .upd_row_i(upd_row_i), .upd_bank_i(upd_bank_i),
        .upd_wdata_i(upd_wdata_i), .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o),
        .ram_wdata_o(ram_wdata_o), .busy_o(busy_o), .sweep_done_o(sweep_done_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: "the table is being swept" plus the next row to write,
    // the pattern being written, a pending done pulse and a saturating drop tally.
    bit sweeping;
    int next_row;
    int pattern;
    bit done_pending;
    int drops;
    int write_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit dbg, input bit uv,
                        input int row, input int bank, input int wd);
        logic [1:0] e_we;
        logic [2:0] e_addr;
        logic [5:0] e_wd;
        bit accepted;
        @(posedge clk_i);
        #1;
        rst_i = rst; flush_i = fl; debug_mode_i = dbg; upd_valid_i = uv;
        upd_row_i = 3'(row); upd_bank_i = 1'(bank); upd_wdata_i = 3'(wd);
        #2;
        e_we = '0; e_addr = '0; e_wd = '0;
        accepted = uv && !dbg;
        if (rst) begin
            e_we = '0;
        end else if (sweeping) begin
            e_we = 2'b11;
            e_addr = 3'(next_row);
            e_wd = {3'(pattern), 3'(pattern)};
        end else if (accepted && !fl) begin
            e_we[bank] = 1'b1;
            e_addr = 3'(row);
            e_wd = 6'(wd) << (3 * bank);
        end
        chk("we", 32'(ram_we_o), 32'(e_we));
        chk("waddr", 32'(ram_waddr_o), 32'(e_addr));
        chk("wdata", 32'(ram_wdata_o), 32'(e_wd));
        chk("busy", 32'(busy_o), 32'(rst || sweeping));
        chk("done", 32'(sweep_done_o), 32'(rst ? 1'b0 : done_pending));
        chk("drop", 32'(drop_cnt_o), 32'(rst ? 0 : drops));
        if (ram_we_o == 2'b11) write_cycles++;
        // Advance the model across the coming clock edge.
        if (rst) begin
            sweeping = 1; next_row = 0; pattern = 0; done_pending = 0; drops = 0;
        end else begin
            if (accepted && (sweeping || fl) && drops < DROP_MAX) drops++;
            done_pending = 0;
            if (fl) begin
                sweeping = 1; next_row = 0; pattern = 2;
            end else if (sweeping) begin
                if (next_row == NR_ROWS - 1) begin
                    sweeping = 0; next_row = 0; done_pending = 1;
                end else begin
                    next_row++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1; flush_i = 0; debug_mode_i = 0; upd_valid_i = 0;
        upd_row_i = 0; upd_bank_i = 0; upd_wdata_i = 0;
        sweeping = 1; next_row = 0; pattern = 0; done_pending = 0; drops = 0;

        // Reset held for 3 cycles, then the INIT sweep: exactly 8 full-bank writes.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        write_cycles = 0;
        idle(9);
        chk("init_len", 32'(write_cycles), 32'd8);

        // Plain update in IDLE.
        step(0, 0, 0, 1, 5, 1, 7);
        idle(1);

        // Flush with a same-cycle update: no write, one drop, then a FLUSH sweep.
        step(0, 1, 0, 1, 2, 0, 5);
        write_cycles = 0;
        idle(9);
        chk("flush_len", 32'(write_cycles), 32'd8);

        // Flush again, restart the sweep while writing row 4.
        step(0, 1, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0, 0, 0);
        write_cycles = 0;
        idle(9);
        chk("restart_len", 32'(write_cycles), 32'd8);

        // Debug mode suppresses updates without counting them.
        step(0, 0, 1, 1, 3, 0, 6);
        step(0, 0, 1, 1, 4, 1, 6);

        // Five updates during a sweep saturate the 2-bit drop counter.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, i, i % 2, 3);
        idle(4);
        chk("drop_sat", 32'(drop_cnt_o), 32'd3);

        // Reset arriving mid-FLUSH at row 3, then INIT from row 0.
        step(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
